instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
Upstream stage of the 8-bit mini CPU. It holds a loadable program memory of 4-bit opcodes and a program counter, and sequences fetches. It presents one opcode at a time on Instruction, which feeds the combinational InstructionDecoder. Issue uses a Valid/Ready handshake with the execute datapath, and run and single-step control are supported.

Parameters:
ADDR_W, 4, program counter / memory address width; memory depth = 2**ADDR_W entries
OP_W, 4, opcode width; fixed at 4 to match the decoder input

Ports:
Clk  in  1  single system clock; all state updates on the rising edge
Reset  in  1  synchronous, active-high reset
LoadEn  in  1  program-memory write strobe; honoured only when not Busy
LoadAddr  in  ADDR_W  program-memory write address
LoadData  in  OP_W  opcode written at LoadAddr
Start  in  1  begin or resume execution from the current PC (level; sampled in IDLE/PAUSE)
StepMode  in  1  1 = issue exactly one instruction per Start, then PAUSE
Ready  in  1  execute stage accepts Instruction this cycle
Instruction  out  OP_W  opcode to InstructionDecoder; OP_NOP when InstrValid=0
InstrValid  out  1  Instruction is valid and held stable until accepted
PC  out  ADDR_W  address of the current or next instruction
Busy  out  1  high in FETCH or ISSUE
Halted  out  1  high in HALT state

Behaviour:
- Reset (synchronous, active-high) gives: state=IDLE, PC=0, InstrValid=0, Instruction=OP_NOP(4'b1011), Busy=0, Halted=0. Reset does not clear memory contents. Reset mid-operation aborts any pending issue; no instruction is considered accepted.
- Memory: synchronous write; registered read with 1-cycle latency.
- FSM states: IDLE, FETCH, ISSUE, PAUSE, HALT.
  IDLE/PAUSE: Start=1 -> FETCH.
  FETCH: the read address is PC. Next cycle -> ISSUE.
  ISSUE: the registered opcode drives Instruction.
  - If opcode = OP_HALT(4'b1111), the HALT opcode is never issued downstream: InstrValid stays 0, state -> HALT, PC unchanged.
  - Otherwise InstrValid=1. Instruction and InstrValid are held while Ready=0.
  - On InstrValid&&Ready, the transfer completes that cycle.
    - If PC = 2**ADDR_W-1: -> HALT, PC stays. There is no wrap-around.
    - Else if StepMode=1: PC+1, -> PAUSE.
    - Else: PC+1, -> FETCH.
  HALT: Halted=1. Exit only via Reset.
- Latency: Start sampled at edge N gives InstrValid=1 at edge N+2. Free-run throughput is one instruction per 2 cycles with Ready tied high.
- Start while Busy is ignored.
- LoadEn while Busy is ignored; no write occurs.
- LoadEn in IDLE/PAUSE/HALT writes.
- Simultaneous LoadEn and Start in IDLE: the write occurs and the FSM moves to FETCH. A write to the current PC in that same cycle is visible to the fetch, because the read happens the following cycle.
- StepMode is sampled only at the handshake cycle.
- Ready while InstrValid=0 has no effect.

Optional Feature:
- Macro: IFU_BREAKPOINT_EN.
- Defined: adds input ports BpEnable(1) and BpAddr(ADDR_W). In FETCH, if BpEnable=1 and PC==BpAddr, the FSM goes -> PAUSE instead of reading; nothing is issued. The next Start from PAUSE fetches BpAddr normally; the breakpoint is suppressed for exactly that one fetch.
- Undefined: neither port exists and FETCH always reads.

Decomposition:
- Shared package cpu_isa_pkg holds:
  - opcode constants OP_CLR=4'b0000, OP_LOAD=4'b0001, OP_MOV_A=4'b0010, OP_MOV_B=4'b0011, ALU opcodes 0100/1010/0110/0111/1000/1001, OP_NOP=4'b1011, OP_HALT=4'b1111;
  - the FSM state enum.
- The decoder will import the same constants.
- One sub-module: program_rom (2**ADDR_W x OP_W, sync write, registered read).

Test Plan:
- Reset: load 0001,0010,0100,1111 at addresses 0..3; Start with Ready=1, StepMode=0 -> Instruction sequence 0001,0010,0100, each with InstrValid for 1 cycle, spaced 2 cycles apart. Then Halted=1 with PC=3, and 1111 is never seen with InstrValid=1.
- Backpressure: hold Ready=0 for 5 cycles during ISSUE of 0010 -> Instruction and InstrValid stable throughout, PC unchanged. Raise Ready -> exactly one transfer, then PC increments.
- Step mode: StepMode=1, pulse Start three times -> exactly one instruction issued per pulse, PAUSE between pulses, PC=1,2,3 after each.
- Boundary: ADDR_W=2, fill with 0100 only, free-run -> 4 issues, then Halted=1 with PC=3 (no wrap).
- Reset mid-ISSUE with Ready=0 -> next cycle InstrValid=0, Instruction=1011, PC=0, Busy=0. Memory contents are retained on the next Start.
- IFU_BREAKPOINT_EN: BpAddr=2, program 0001,0001,0010,1111 -> PAUSE with PC=2 and no issue. Start -> 0010 issued, then HALT.

Source files
------------

// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions for the 8-bit mini CPU: opcode constants used by
// the fetch unit and the instruction decoder, plus the fetch FSM state type.
package cpu_isa_pkg;

  localparam logic [3:0] OP_CLR   = 4'b0000;
  localparam logic [3:0] OP_LOAD  = 4'b0001;
  localparam logic [3:0] OP_MOV_A = 4'b0010;
  localparam logic [3:0] OP_MOV_B = 4'b0011;
  // ALU opcode group
  localparam logic [3:0] OP_ADD   = 4'b0100;
  localparam logic [3:0] OP_SUB   = 4'b1010;
  localparam logic [3:0] OP_AND   = 4'b0110;
  localparam logic [3:0] OP_OR    = 4'b0111;
  localparam logic [3:0] OP_XOR   = 4'b1000;
  localparam logic [3:0] OP_NOT   = 4'b1001;
  localparam logic [3:0] OP_NOP   = 4'b1011;
  localparam logic [3:0] OP_HALT  = 4'b1111;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_ISSUE = 3'd2,
    ST_PAUSE = 3'd3,
    ST_HALT  = 3'd4
  } ifu_state_t;

endpackage

// File: rtl/instruction_fetch_unit_rom.sv
// program_rom: loadable program store, synchronous write port and a
// registered read port (one-cycle read latency). The read register only
// updates on a read strobe, so the fetched opcode stays put while the
// fetch unit waits for the execute stage.
module program_rom #(
  parameter int ADDR_W = 4,
  parameter int OP_W   = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [OP_W-1:0]   wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [OP_W-1:0]   rdata
);

  logic [OP_W-1:0] mem [2**ADDR_W];
  logic [OP_W-1:0] rdata_reg;

  // Write and registered read; contents are not touched by any reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_reg <= mem[raddr];
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: program counter, program store and fetch/issue
// sequencer feeding the decoder over a Valid/Ready handshake.
// Optional breakpoint support is built when IFU_BREAKPOINT_EN is defined.
module instruction_fetch_unit
  import cpu_isa_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int OP_W   = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              LoadEn,
  input  logic [ADDR_W-1:0] LoadAddr,
  input  logic [OP_W-1:0]   LoadData,
  input  logic              Start,
  input  logic              StepMode,
  input  logic              Ready,
`ifdef IFU_BREAKPOINT_EN
  input  logic              BpEnable,
  input  logic [ADDR_W-1:0] BpAddr,
`endif
  output logic [OP_W-1:0]   Instruction,
  output logic              InstrValid,
  output logic [ADDR_W-1:0] PC,
  output logic              Busy,
  output logic              Halted
);

  localparam logic [ADDR_W-1:0] PC_LAST = '1;

  ifu_state_t        state_reg, state_next;
  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic              rom_re;
  logic              rom_we;
  logic [OP_W-1:0]   rom_data;
  logic              busy;
  logic              is_halt_op;

  assign busy       = (state_reg == ST_FETCH) || (state_reg == ST_ISSUE);
  assign rom_we     = LoadEn && !busy;
  assign is_halt_op = (rom_data == OP_HALT);

  program_rom #(
    .ADDR_W (ADDR_W),
    .OP_W   (OP_W)
  ) u_rom (
    .clk   (Clk),
    .we    (rom_we),
    .waddr (LoadAddr),
    .wdata (LoadData),
    .re    (rom_re),
    .raddr (pc_reg),
    .rdata (rom_data)
  );

`ifdef IFU_BREAKPOINT_EN
  // Set when a breakpoint pauses the FSM so the resumed fetch goes through.
  logic bp_skip_reg, bp_skip_next;

  // Breakpoint suppression flag register.
  always_ff @(posedge Clk) begin
    if (Reset) bp_skip_reg <= 1'b0;
    else       bp_skip_reg <= bp_skip_next;
  end
`endif

  // State and program counter registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg <= ST_IDLE;
      pc_reg    <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
    end
  end

  // Next-state, PC advance and memory read strobe.
  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    rom_re     = 1'b0;
`ifdef IFU_BREAKPOINT_EN
    bp_skip_next = bp_skip_reg;
`endif
    case (state_reg)
      ST_IDLE, ST_PAUSE: begin
        if (Start) state_next = ST_FETCH;
      end
      ST_FETCH: begin
`ifdef IFU_BREAKPOINT_EN
        if (BpEnable && (pc_reg == BpAddr) && !bp_skip_reg) begin
          state_next   = ST_PAUSE;
          bp_skip_next = 1'b1;
        end else begin
          rom_re       = 1'b1;
          bp_skip_next = 1'b0;
          state_next   = ST_ISSUE;
        end
`else
        rom_re     = 1'b1;
        state_next = ST_ISSUE;
`endif
      end
      ST_ISSUE: begin
        // A HALT opcode is consumed here and never offered downstream.
        if (is_halt_op) begin
          state_next = ST_HALT;
        end else if (Ready) begin
          if (pc_reg == PC_LAST) begin
            state_next = ST_HALT;
          end else begin
            pc_next    = pc_reg + 1'b1;
            state_next = StepMode ? ST_PAUSE : ST_FETCH;
          end
        end
      end
      ST_HALT: state_next = ST_HALT;
      default: state_next = ST_IDLE;
    endcase
  end

  assign InstrValid  = (state_reg == ST_ISSUE) && !is_halt_op;
  assign Instruction = InstrValid ? rom_data : OP_NOP;
  assign PC          = pc_reg;
  assign Busy        = busy;
  assign Halted      = (state_reg == ST_HALT);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Randomised scoreboard bench for instruction_fetch_unit. The reference
// model walks the program image to predict the issued (PC, opcode) stream;
// a negedge monitor pops and compares on every handshake.
module tb_instruction_fetch_unit;
  import cpu_isa_pkg::*;

  localparam int DEPTH = 16;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1, LoadEn = 1'b0, Start = 1'b0, StepMode = 1'b0, Ready = 1'b0;
  logic [3:0] LoadAddr = '0, LoadData = '0;
  logic [3:0] Instruction, PC;
  logic       InstrValid, Busy, Halted;
`ifdef IFU_BREAKPOINT_EN
  logic       BpEnable = 1'b0;
  logic [3:0] BpAddr = '0;
`endif

  always #5 Clk = ~Clk;

  instruction_fetch_unit #(.ADDR_W(4), .OP_W(4)) dut (
    .Clk(Clk), .Reset(Reset), .LoadEn(LoadEn), .LoadAddr(LoadAddr),
    .LoadData(LoadData), .Start(Start), .StepMode(StepMode), .Ready(Ready),
`ifdef IFU_BREAKPOINT_EN
    .BpEnable(BpEnable), .BpAddr(BpAddr),
`endif
    .Instruction(Instruction), .InstrValid(InstrValid), .PC(PC),
    .Busy(Busy), .Halted(Halted)
  );

  int n_vec = 0, n_err = 0;
  logic [7:0] exp_q[$];            // {pc, opcode}
  logic [3:0] model_mem [DEPTH];
  bit   rand_ready = 0;
  bit   check_gap = 0;
  int   cyc = 0, last_hs = -1;
  bit   prev_hold = 0;
  logic [3:0] prev_instr, prev_pc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge Clk) cyc++;

  // Random backpressure when enabled.
  always @(posedge Clk) begin
    #1;
    if (rand_ready) Ready = 1'($urandom_range(0, 1));
  end

  // Monitor: stability under backpressure and scoreboard on handshakes.
  always @(negedge Clk) begin
    logic [7:0] e;
    if (Reset) begin
      prev_hold = 0;
    end else begin
      if (prev_hold) begin
        chk("hold_valid", InstrValid, 1);
        chk("hold_instr", Instruction, prev_instr);
        chk("hold_pc", PC, prev_pc);
      end
      if (InstrValid) chk("no_halt_issued", (Instruction == OP_HALT), 0);
      if (InstrValid && Ready) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_issue: got op %0h pc %0h, expected none", Instruction, PC);
        end else begin
          e = exp_q.pop_front();
          chk("issue_op", Instruction, e[3:0]);
          chk("issue_pc", PC, e[7:4]);
        end
        if (check_gap && last_hs >= 0) chk("issue_gap", cyc - last_hs, 2);
        last_hs = cyc;
      end
      prev_hold  = InstrValid && !Ready;
      prev_instr = Instruction;
      prev_pc    = PC;
    end
  end

  task automatic step();
    @(posedge Clk); #1;
  endtask

  task automatic do_reset();
    Reset = 1; Start = 0; LoadEn = 0; Ready = 0; rand_ready = 0; check_gap = 0;
    step();
    Reset = 0;
    exp_q.delete();
  endtask

  task automatic load_prog();
    for (int i = 0; i < DEPTH; i++) begin
      LoadEn = 1; LoadAddr = 4'(i); LoadData = model_mem[i];
      step();
    end
    LoadEn = 0;
  endtask

  // Free-run prediction: issue each opcode until a HALT opcode or the last address.
  task automatic expect_run(input int start, output int fin);
    int pc = start;
    while (1) begin
      if (model_mem[pc] == OP_HALT) break;
      exp_q.push_back({4'(pc), model_mem[pc]});
      if (pc == DEPTH - 1) break;
      pc++;
    end
    fin = pc;
  endtask

  task automatic wait_halt(input int bound);
    int c = 0;
    while (!Halted && c < bound) begin step(); c++; end
    chk("halt_reached", Halted, 1);
  endtask

  task automatic wait_idle(input bit rand_start);
    int c = 0;
    do begin
      if (rand_start) Start = 1'($urandom_range(0, 1));
      step(); c++;
    end while (Busy && c < 200);
    Start = 0;
    chk("idle_reached", Busy, 0);
  endtask

  task automatic free_run(input bit garbage);
    int fin, c;
    expect_run(0, fin);
    StepMode = 0; rand_ready = 1; Start = 1;
    step();
    c = 0;
    while (!Halted && c < 400) begin
      Start = 1'($urandom_range(0, 1));
      if (garbage) begin
        LoadEn = 1'($urandom_range(0, 1));
        LoadAddr = 4'($urandom_range(0, 15));
        LoadData = 4'($urandom_range(0, 15));
      end
      step(); c++;
    end
    Start = 0; LoadEn = 0; rand_ready = 0;
    chk("halt_reached", Halted, 1);
    chk("final_pc", PC, fin);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  task automatic step_run();
    int pc = 0;
    bit halted = 0;
    StepMode = 1; rand_ready = 1;
    for (int p = 0; p < DEPTH + 1 && !halted; p++) begin
      if (model_mem[pc] == OP_HALT) halted = 1;
      else begin
        exp_q.push_back({4'(pc), model_mem[pc]});
        if (pc == DEPTH - 1) halted = 1; else pc++;
      end
      Start = 1;
      step();
      Start = 0;
      wait_idle(1);
      chk("step_pc", PC, pc);
      chk("step_halted", Halted, halted);
      chk("step_drained", exp_q.size(), 0);
    end
    rand_ready = 0; StepMode = 0;
  endtask

  initial begin
    int fin;
    // Reset state
    do_reset();
    chk("rst_valid", InstrValid, 0);
    chk("rst_instr", Instruction, OP_NOP);
    chk("rst_pc", PC, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_halted", Halted, 0);

    // Directed run: 0001,0010,0100,1111 with Ready tied high
    for (int i = 0; i < DEPTH; i++) model_mem[i] = OP_NOP;
    model_mem[0] = OP_LOAD; model_mem[1] = OP_MOV_A; model_mem[2] = OP_ADD; model_mem[3] = OP_HALT;
    load_prog();
    expect_run(0, fin);
    Ready = 1; check_gap = 1; last_hs = -1; Start = 1;
    step();
    Start = 0;
    chk("latency_n1", InstrValid, 0);
    step();
    chk("latency_n2", InstrValid, 1);
    wait_halt(50);
    chk("dir_pc", PC, 3);
    chk("dir_drained", exp_q.size(), 0);
    check_gap = 0;
    Start = 1;
    repeat (4) step();
    Start = 0;
    chk("halt_sticky", Halted, 1);
    chk("halt_pc", PC, 3);

    // Backpressure on the 0010 issue
    do_reset();
    expect_run(0, fin);
    Start = 1; step(); Start = 0;
    for (int c = 0; c < 20 && !InstrValid; c++) step();
    Ready = 1; step(); Ready = 0;
    for (int c = 0; c < 20 && !InstrValid; c++) step();
    repeat (5) step();
    chk("bp_pc_held", PC, 1);
    Ready = 1; step(); Ready = 0;
    chk("bp_pc_inc", PC, 2);
    Ready = 1;
    wait_halt(50);
    chk("bp_drained", exp_q.size(), 0);

    // Write and Start in the same IDLE cycle: fetch sees the new opcode
    do_reset();
    model_mem[0] = OP_AND;
    expect_run(0, fin);
    LoadEn = 1; LoadAddr = 0; LoadData = OP_AND; Start = 1; Ready = 1;
    step();
    LoadEn = 0; Start = 0;
    wait_halt(50);
    chk("ldst_drained", exp_q.size(), 0);

    // Reset mid-issue aborts; memory survives
    do_reset();
    Start = 1; step(); Start = 0;
    for (int c = 0; c < 20 && !InstrValid; c++) step();
    Reset = 1; step(); Reset = 0;
    exp_q.delete();
    chk("mid_valid", InstrValid, 0);
    chk("mid_instr", Instruction, OP_NOP);
    chk("mid_pc", PC, 0);
    chk("mid_busy", Busy, 0);
    free_run(0);

`ifdef IFU_BREAKPOINT_EN
    do_reset();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = OP_NOP;
    model_mem[0] = OP_LOAD; model_mem[1] = OP_LOAD; model_mem[2] = OP_MOV_A; model_mem[3] = OP_HALT;
    load_prog();
    exp_q.push_back({4'd0, OP_LOAD});
    exp_q.push_back({4'd1, OP_LOAD});
    BpEnable = 1; BpAddr = 2; Ready = 1; Start = 1;
    step(); Start = 0;
    wait_idle(0);
    chk("bpk_pc", PC, 2);
    chk("bpk_halted", Halted, 0);
    chk("bpk_drained", exp_q.size(), 0);
    expect_run(2, fin);
    Start = 1; step(); Start = 0;
    wait_halt(50);
    chk("bpk_final_pc", PC, fin);
    chk("bpk_final_drained", exp_q.size(), 0);
    BpEnable = 0;
`endif

    // Randomised programs: free-run with ignored writes, and step mode
    for (int it = 0; it < 12; it++) begin
      do_reset();
      for (int i = 0; i < DEPTH; i++) begin
        model_mem[i] = 4'($urandom_range(0, 15));
        if (it % 4 == 0 && model_mem[i] == OP_HALT) model_mem[i] = OP_NOP;
      end
      load_prog();
      if (it % 2 == 0) free_run(1);
      else step_run();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
